// File: rtl/data_sram_bridge_if.sv
// SRAM-like request/addr_ok/data_ok bus between the data RAM bridge (master)
// and the data cache or bus interface (slave).
interface data_sram_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wstrb,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wstrb,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// Turns the LSU's single-cycle data RAM port into one SRAM-like transaction per
// access, freezing the pipeline while it is outstanding and holding load data for MEM.
module data_sram_bridge (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       data_ram_en,
  input  logic [3:0]                 data_ram_wen,
  input  logic [31:0]                data_ram_addr,
  input  logic [31:0]                data_ram_wdata,
  output logic [31:0]                data_ram_rdata,
  input  logic                       pipe_stall,
  input  logic                       flush,
  output logic                       stall_req,
  data_sram_bridge_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        cancel_reg, cancel_next;
  logic        wr_reg, wr_next;
  logic [1:0]  size_reg, size_next;
  logic [31:0] addr_reg, addr_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_stage_reg, rdata_stage_next;
  logic [31:0] rdata_out_reg, rdata_out_next;

  // Request encoding derived from the byte enables of the EX access.
  logic [2:0]  wen_bit [4];
  logic [2:0]  wen_count;
  logic [1:0]  wen_low;
  logic [1:0]  enc_size;
  logic [31:0] enc_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wen_bit
      assign wen_bit[gi] = {2'b00, data_ram_wen[gi]};
    end
  endgenerate

  assign wen_count = wen_bit[0] + wen_bit[1] + wen_bit[2] + wen_bit[3];

  always_comb begin
    wen_low = 2'd0;
    casez (data_ram_wen)
      4'b???1: wen_low = 2'd0;
      4'b??10: wen_low = 2'd1;
      4'b?100: wen_low = 2'd2;
      4'b1000: wen_low = 2'd3;
      default: wen_low = 2'd0;
    endcase
  end

  always_comb begin
    enc_size = 2'd2;
    if (data_ram_wen != 4'b0000) begin
      case (wen_count)
        3'd1:    enc_size = 2'd0;
        3'd2:    enc_size = 2'd1;
        default: enc_size = 2'd2;
      endcase
    end
  end

  assign enc_addr = {data_ram_addr[31:2], (enc_size == 2'd2) ? 2'b00 : wen_low};

  always_comb begin
    state_next       = state_reg;
    cancel_next      = cancel_reg;
    wr_next          = wr_reg;
    size_next        = size_reg;
    addr_next        = addr_reg;
    wstrb_next       = wstrb_reg;
    wdata_next       = wdata_reg;
    rdata_stage_next = rdata_stage_reg;
    rdata_out_next   = rdata_out_reg;

    case (state_reg)
      IDLE: begin
        if (data_ram_en && !flush) begin
          wr_next    = |data_ram_wen;
          size_next  = enc_size;
          addr_next  = enc_addr;
          wstrb_next = data_ram_wen;
          wdata_next = data_ram_wdata;
          state_next = REQ;
        end
      end
      REQ: begin
        // Once accepted the slave will answer, so a flush only marks it for discard.
        if (bus.data_addr_ok) begin
          cancel_next = flush;
          state_next  = WAIT;
        end else if (flush) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (bus.data_data_ok) begin
          if (cancel_reg || flush) begin
            cancel_next = 1'b0;
            state_next  = IDLE;
          end else begin
            rdata_stage_next = bus.data_rdata;
            state_next       = DONE;
          end
        end else if (flush) begin
          cancel_next = 1'b1;
        end
      end
      DONE: begin
        // Output only moves on the edge where the pipeline itself advances.
        if (flush) begin
          state_next = IDLE;
        end else if (!pipe_stall) begin
          rdata_out_next = rdata_stage_reg;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      cancel_reg      <= 1'b0;
      wr_reg          <= 1'b0;
      size_reg        <= 2'd0;
      addr_reg        <= 32'd0;
      wstrb_reg       <= 4'd0;
      wdata_reg       <= 32'd0;
      rdata_stage_reg <= 32'd0;
      rdata_out_reg   <= 32'd0;
    end else begin
      state_reg       <= state_next;
      cancel_reg      <= cancel_next;
      wr_reg          <= wr_next;
      size_reg        <= size_next;
      addr_reg        <= addr_next;
      wstrb_reg       <= wstrb_next;
      wdata_reg       <= wdata_next;
      rdata_stage_reg <= rdata_stage_next;
      rdata_out_reg   <= rdata_out_next;
    end
  end

  assign stall_req = ((state_reg == IDLE) && data_ram_en && !flush)
                   || (state_reg == REQ) || (state_reg == WAIT);

  assign bus.data_req   = (state_reg == REQ);
  assign bus.data_wr    = wr_reg;
  assign bus.data_size  = size_reg;
  assign bus.data_addr  = addr_reg;
  assign bus.data_wstrb = wr_reg ? wstrb_reg : 4'd0;
  assign bus.data_wdata = wdata_reg;
  assign data_ram_rdata = rdata_out_reg;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: per-cycle vector table for the main flows,
// hand-written sequences for slave back-pressure, pipe_stall hold and async reset.
module tb_data_sram_bridge;

  logic        clk;
  logic        resetn;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic [31:0] data_ram_addr;
  logic [31:0] data_ram_wdata;
  logic [31:0] data_ram_rdata;
  logic        pipe_stall;
  logic        flush;
  logic        stall_req;

  data_sram_bridge_if bus_if ();

  data_sram_bridge dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_ram_en    (data_ram_en),
    .data_ram_wen   (data_ram_wen),
    .data_ram_addr  (data_ram_addr),
    .data_ram_wdata (data_ram_wdata),
    .data_ram_rdata (data_ram_rdata),
    .pipe_stall     (pipe_stall),
    .flush          (flush),
    .stall_req      (stall_req),
    .bus            (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ps;
    logic        fl;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        e_stall;
    logic        e_req;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdout;
  } vec_t;

  vec_t vecs[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] CF = 32'hCAFEF00D;

  function automatic vec_t mv(
    input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
    input logic ps, input logic fl, input logic aok, input logic dok, input logic [31:0] rd,
    input logic e_stall, input logic e_req, input logic e_wr, input logic [1:0] e_size,
    input logic [31:0] e_addr, input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
    input logic [31:0] e_rdout);
    vec_t v;
    v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.ps = ps; v.fl = fl; v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_stall = e_stall; v.e_req = e_req; v.e_wr = e_wr; v.e_size = e_size;
    v.e_addr = e_addr; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata; v.e_rdout = e_rdout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic [31:0] addr, input logic ps, input logic fl,
                        input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    data_ram_en = en; data_ram_wen = 4'h0; data_ram_addr = addr; data_ram_wdata = 32'h0;
    pipe_stall = ps; flush = fl;
    bus_if.data_addr_ok = aok; bus_if.data_data_ok = dok; bus_if.data_rdata = rd;
    #1;
  endtask

  int hs;

  initial begin
    // ---- vector table ----
    // load word 0x1004, best-case slave
    vecs.push_back(mv(1,4'h0,32'h1004,0,0,0,0,0,0,          1,0,0,2'd0,32'h0,4'h0,32'h0,32'h0));
    vecs.push_back(mv(1,4'h0,32'h1004,0,0,0,1,0,0,          1,1,0,2'd2,32'h1004,4'h0,32'h0,32'h0));
    vecs.push_back(mv(1,4'h0,32'h1004,0,0,0,0,1,DB,         1,0,0,2'd2,32'h1004,4'h0,32'h0,32'h0));
    vecs.push_back(mv(1,4'h0,32'h1004,0,0,0,0,0,0,          0,0,0,2'd2,32'h1004,4'h0,32'h0,32'h0));
    vecs.push_back(mv(0,4'h0,32'h0,0,0,0,0,0,0,             0,0,0,2'd2,32'h1004,4'h0,32'h0,DB));
    // back-to-back stores at 0x2000
    vecs.push_back(mv(1,4'h4,32'h2000,32'h00AA0000,0,0,0,0,0,  1,0,0,2'd2,32'h1004,4'h0,32'h0,DB));
    vecs.push_back(mv(1,4'h4,32'h2000,32'h00AA0000,0,0,1,0,0,  1,1,1,2'd0,32'h2002,4'h4,32'h00AA0000,DB));
    vecs.push_back(mv(1,4'h4,32'h2000,32'h00AA0000,0,0,0,1,DB, 1,0,1,2'd0,32'h2002,4'h4,32'h00AA0000,DB));
    vecs.push_back(mv(1,4'h4,32'h2000,32'h00AA0000,0,0,0,0,0,  0,0,1,2'd0,32'h2002,4'h4,32'h00AA0000,DB));
    vecs.push_back(mv(1,4'hC,32'h2000,32'hBBBB0000,0,0,0,0,0,  1,0,1,2'd0,32'h2002,4'h4,32'h00AA0000,DB));
    vecs.push_back(mv(1,4'hC,32'h2000,32'hBBBB0000,0,0,1,0,0,  1,1,1,2'd1,32'h2002,4'hC,32'hBBBB0000,DB));
    vecs.push_back(mv(1,4'hC,32'h2000,32'hBBBB0000,0,0,0,1,DB, 1,0,1,2'd1,32'h2002,4'hC,32'hBBBB0000,DB));
    vecs.push_back(mv(1,4'hC,32'h2000,32'hBBBB0000,0,0,0,0,0,  0,0,1,2'd1,32'h2002,4'hC,32'hBBBB0000,DB));
    vecs.push_back(mv(1,4'h7,32'h2000,32'h00CCCCCC,0,0,0,0,0,  1,0,1,2'd1,32'h2002,4'hC,32'hBBBB0000,DB));
    vecs.push_back(mv(1,4'h7,32'h2000,32'h00CCCCCC,0,0,1,0,0,  1,1,1,2'd2,32'h2000,4'h7,32'h00CCCCCC,DB));
    vecs.push_back(mv(1,4'h7,32'h2000,32'h00CCCCCC,0,0,0,1,DB, 1,0,1,2'd2,32'h2000,4'h7,32'h00CCCCCC,DB));
    vecs.push_back(mv(1,4'h7,32'h2000,32'h00CCCCCC,0,0,0,0,0,  0,0,1,2'd2,32'h2000,4'h7,32'h00CCCCCC,DB));
    vecs.push_back(mv(1,4'hF,32'h2000,32'hDDDDDDDD,0,0,0,0,0,  1,0,1,2'd2,32'h2000,4'h7,32'h00CCCCCC,DB));
    vecs.push_back(mv(1,4'hF,32'h2000,32'hDDDDDDDD,0,0,1,0,0,  1,1,1,2'd2,32'h2000,4'hF,32'hDDDDDDDD,DB));
    vecs.push_back(mv(1,4'hF,32'h2000,32'hDDDDDDDD,0,0,0,1,DB, 1,0,1,2'd2,32'h2000,4'hF,32'hDDDDDDDD,DB));
    vecs.push_back(mv(1,4'hF,32'h2000,32'hDDDDDDDD,0,0,0,0,0,  0,0,1,2'd2,32'h2000,4'hF,32'hDDDDDDDD,DB));
    vecs.push_back(mv(0,4'h0,32'h0,0,0,0,0,0,0,                0,0,1,2'd2,32'h2000,4'hF,32'hDDDDDDDD,DB));
    // flush in WAIT discards data, then a normal (unaligned-address) load
    vecs.push_back(mv(1,4'h0,32'h3000,0,0,0,0,0,0,           1,0,1,2'd2,32'h2000,4'hF,32'hDDDDDDDD,DB));
    vecs.push_back(mv(1,4'h0,32'h3000,0,0,0,1,0,0,           1,1,0,2'd2,32'h3000,4'h0,32'h0,DB));
    vecs.push_back(mv(1,4'h0,32'h3000,0,0,1,0,0,0,           1,0,0,2'd2,32'h3000,4'h0,32'h0,DB));
    vecs.push_back(mv(0,4'h0,32'h0,0,0,0,0,1,32'h12345678,   1,0,0,2'd2,32'h3000,4'h0,32'h0,DB));
    vecs.push_back(mv(0,4'h0,32'h0,0,0,0,0,0,0,              0,0,0,2'd2,32'h3000,4'h0,32'h0,DB));
    vecs.push_back(mv(1,4'h0,32'h300B,0,0,0,0,0,0,           1,0,0,2'd2,32'h3000,4'h0,32'h0,DB));
    vecs.push_back(mv(1,4'h0,32'h300B,0,0,0,1,0,0,           1,1,0,2'd2,32'h3008,4'h0,32'h0,DB));
    vecs.push_back(mv(1,4'h0,32'h300B,0,0,0,0,1,CF,          1,0,0,2'd2,32'h3008,4'h0,32'h0,DB));
    vecs.push_back(mv(1,4'h0,32'h300B,0,0,0,0,0,0,           0,0,0,2'd2,32'h3008,4'h0,32'h0,DB));
    vecs.push_back(mv(0,4'h0,32'h0,0,0,0,0,0,0,              0,0,0,2'd2,32'h3008,4'h0,32'h0,CF));
    // flush in REQ without addr_ok withdraws; stray data_ok in IDLE ignored
    vecs.push_back(mv(1,4'h0,32'h4000,0,0,0,0,0,0,           1,0,0,2'd2,32'h3008,4'h0,32'h0,CF));
    vecs.push_back(mv(1,4'h0,32'h4000,0,0,1,0,0,0,           1,1,0,2'd2,32'h4000,4'h0,32'h0,CF));
    vecs.push_back(mv(0,4'h0,32'h0,0,0,0,0,1,32'h99999999,   0,0,0,2'd2,32'h4000,4'h0,32'h0,CF));
    vecs.push_back(mv(0,4'h0,32'h0,0,0,0,0,0,0,              0,0,0,2'd2,32'h4000,4'h0,32'h0,CF));

    // ---- reset ----
    resetn = 1'b0; data_ram_en = 1'b0; data_ram_wen = 4'h0; data_ram_addr = 32'h0;
    data_ram_wdata = 32'h0; pipe_stall = 1'b0; flush = 1'b0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall_req",  {31'd0, stall_req}, 32'd0);
    chk("reset data_req",   {31'd0, bus_if.data_req}, 32'd0);
    chk("reset data_wr",    {31'd0, bus_if.data_wr}, 32'd0);
    chk("reset data_size",  {30'd0, bus_if.data_size}, 32'd0);
    chk("reset data_addr",  bus_if.data_addr, 32'd0);
    chk("reset data_wstrb", {28'd0, bus_if.data_wstrb}, 32'd0);
    chk("reset data_wdata", bus_if.data_wdata, 32'd0);
    chk("reset rdata",      data_ram_rdata, 32'd0);
    $display("[TB] reset state checked");
    resetn = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      data_ram_en = vecs[i].en; data_ram_wen = vecs[i].wen;
      data_ram_addr = vecs[i].addr; data_ram_wdata = vecs[i].wdata;
      pipe_stall = vecs[i].ps; flush = vecs[i].fl;
      bus_if.data_addr_ok = vecs[i].aok; bus_if.data_data_ok = vecs[i].dok;
      bus_if.data_rdata = vecs[i].rd;
      #1;
      chk($sformatf("vec%0d stall_req", i), {31'd0, stall_req}, {31'd0, vecs[i].e_stall});
      chk($sformatf("vec%0d data_req", i),  {31'd0, bus_if.data_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d data_wr", i),   {31'd0, bus_if.data_wr}, {31'd0, vecs[i].e_wr});
      chk($sformatf("vec%0d data_size", i), {30'd0, bus_if.data_size}, {30'd0, vecs[i].e_size});
      chk($sformatf("vec%0d data_addr", i), bus_if.data_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d data_wstrb", i), {28'd0, bus_if.data_wstrb}, {28'd0, vecs[i].e_wstrb});
      chk($sformatf("vec%0d data_wdata", i), bus_if.data_wdata, vecs[i].e_wdata);
      chk($sformatf("vec%0d ram_rdata", i), data_ram_rdata, vecs[i].e_rdout);
      $display("[TB] vec %0d: stall=%b req=%b wr=%b size=%0d addr=%h wstrb=%h rdata=%h",
               i, stall_req, bus_if.data_req, bus_if.data_wr, bus_if.data_size,
               bus_if.data_addr, bus_if.data_wstrb, data_ram_rdata);
    end

    // ---- addr_ok withheld 5 cycles, data_ok 3 cycles after acceptance ----
    hs = 0;
    set_in(1, 32'h5000, 0, 0, 0, 0, 32'h0);
    chk("hold latch stall", {31'd0, stall_req}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 32'h5000, 0, 0, 0, 0, 32'h0);
      chk($sformatf("hold req c%0d", i), {31'd0, bus_if.data_req}, 32'd1);
      chk($sformatf("hold addr c%0d", i), bus_if.data_addr, 32'h5000);
      chk($sformatf("hold stall c%0d", i), {31'd0, stall_req}, 32'd1);
    end
    set_in(1, 32'h5000, 0, 0, 1, 0, 32'h0);
    chk("hold accept req", {31'd0, bus_if.data_req}, 32'd1);
    chk("hold accept addr", bus_if.data_addr, 32'h5000);
    if (bus_if.data_req && bus_if.data_addr_ok) hs++;
    for (int i = 0; i < 2; i++) begin
      set_in(1, 32'h5000, 0, 0, 1, 0, 32'h0);
      chk($sformatf("hold wait stall c%0d", i), {31'd0, stall_req}, 32'd1);
      if (bus_if.data_req && bus_if.data_addr_ok) hs++;
    end
    set_in(1, 32'h5000, 0, 0, 1, 1, 32'h0BADF00D);
    chk("hold data_ok stall", {31'd0, stall_req}, 32'd1);
    if (bus_if.data_req && bus_if.data_addr_ok) hs++;
    set_in(1, 32'h5000, 0, 0, 1, 0, 32'h0);
    chk("hold done stall", {31'd0, stall_req}, 32'd0);
    if (bus_if.data_req && bus_if.data_addr_ok) hs++;
    set_in(0, 32'h0, 0, 0, 1, 0, 32'h0);
    chk("hold rdata", data_ram_rdata, 32'h0BADF00D);
    if (bus_if.data_req && bus_if.data_addr_ok) hs++;
    chk("hold handshake count", hs, 32'd1);
    $display("[TB] back-pressure load: handshakes=%0d rdata=%h", hs, data_ram_rdata);

    // ---- pipe_stall hold in DONE ----
    set_in(1, 32'h7000, 0, 0, 0, 0, 32'h0);
    set_in(1, 32'h7000, 0, 0, 1, 0, 32'h0);
    set_in(1, 32'h7000, 0, 0, 0, 1, 32'hAAAAAAAA);
    set_in(1, 32'h7000, 0, 0, 0, 0, 32'h0);
    set_in(0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("pstall prior rdata", data_ram_rdata, 32'hAAAAAAAA);
    set_in(1, 32'h7004, 0, 0, 0, 0, 32'h0);
    set_in(1, 32'h7004, 0, 0, 1, 0, 32'h0);
    set_in(1, 32'h7004, 0, 0, 0, 1, 32'h55555555);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h7004, 1, 0, 0, 0, 32'h0);
      chk($sformatf("pstall hold rdata c%0d", i), data_ram_rdata, 32'hAAAAAAAA);
      chk($sformatf("pstall done stall c%0d", i), {31'd0, stall_req}, 32'd0);
    end
    set_in(1, 32'h7004, 0, 0, 0, 0, 32'h0);
    chk("pstall release rdata", data_ram_rdata, 32'hAAAAAAAA);
    set_in(0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("pstall new rdata", data_ram_rdata, 32'h55555555);
    $display("[TB] pipe_stall hold: rdata=%h", data_ram_rdata);

    // ---- async reset during REQ ----
    set_in(1, 32'h6000, 0, 0, 0, 0, 32'h0);
    set_in(1, 32'h6000, 0, 0, 0, 0, 32'h0);
    chk("rst pre req", {31'd0, bus_if.data_req}, 32'd1);
    #2;
    data_ram_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst data_req",  {31'd0, bus_if.data_req}, 32'd0);
    chk("rst data_size", {30'd0, bus_if.data_size}, 32'd0);
    chk("rst data_addr", bus_if.data_addr, 32'd0);
    chk("rst stall_req", {31'd0, stall_req}, 32'd0);
    chk("rst rdata",     data_ram_rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst release req", {31'd0, bus_if.data_req}, 32'd0);
    set_in(1, 32'h6004, 0, 0, 0, 0, 32'h0);
    chk("rst idle latch stall", {31'd0, stall_req}, 32'd1);
    chk("rst idle latch req", {31'd0, bus_if.data_req}, 32'd0);
    set_in(1, 32'h6004, 0, 0, 0, 0, 32'h0);
    chk("rst new req", {31'd0, bus_if.data_req}, 32'd1);
    chk("rst new addr", bus_if.data_addr, 32'h6004);
    $display("[TB] async reset during REQ: req=%b addr=%h", bus_if.data_req, bus_if.data_addr);
    set_in(0, 32'h0, 0, 0, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Converts the load/store unit's single-cycle data RAM port (`data_ram_en/wen/addr/wdata` in EX, `data_ram_rdata` consumed in MEM) into a SRAM-like request/`addr_ok`/`data_ok` master handshake toward the data cache/bus. It sits directly downstream of the LSU in the EX→MEM path. While a transaction is outstanding it raises `stall_req` to freeze the pipeline. It holds load data stable for the MEM stage until the pipeline advances.

## Interface
Parameters: none (32-bit address/data fixed).

- `clk` in 1 — sole clock, rising edge
- `resetn` in 1 — asynchronous, active-low reset
- `data_ram_en` in 1 — access request from LSU (EX stage), already exception-gated
- `data_ram_wen` in 4 — byte write enables; 0 means load
- `data_ram_addr` in 32 — byte address
- `data_ram_wdata` in 32 — lane-aligned store data
- `data_ram_rdata` out 32 — full load word delivered to LSU in MEM
- `pipe_stall` in 1 — stall from all other sources; pipeline advances on edges where `stall_req|pipe_stall`=0
- `flush` in 1 — exception/eret flush, one-cycle pulse
- `stall_req` out 1 — bridge requests pipeline freeze
- `data_req` out 1 — SRAM-like request valid
- `data_wr` out 1 — 1 = write
- `data_size` out 2 — 0 byte, 1 half, 2 word
- `data_addr` out 32 — request address
- `data_wstrb` out 4 — byte strobes (write only, else 0)
- `data_wdata` out 32 — write data
- `data_addr_ok` in 1 — request accepted
- `data_data_ok` in 1 — read data valid / write complete
- `data_rdata` in 32 — read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Flag `cancel` (1 bit). Staging register `rdata_stage` and output register `rdata_out`. `data_ram_rdata` = `rdata_out`.
- IDLE: if `data_ram_en & ~flush`, latch addr/wen/wdata into request registers. Go to REQ.
- Request encoding, registered at latch:
  - `data_wr` = |wen.
  - Load: size 2, addr = {addr[31:2],2'b00}, wstrb 0.
  - Store: popcount(wen)=1 → size 0; =2 → size 1; ≥3 → size 2.
  - Store addr: for size 0 and 1, addr[1:0] = index of lowest set wen bit; for size 2, addr[1:0] = 00. Upper bits are always addr[31:2].
  - Store wstrb = wen; wdata passed unchanged.
- REQ: `data_req`=1 and outputs held stable.
  - On `data_addr_ok` → WAIT; drop `data_req` the next cycle.
  - `flush` with `data_addr_ok` the same cycle → WAIT with `cancel`=1.
  - `flush` without `data_addr_ok` → drop `data_req` and go to IDLE (request withdrawn, no transaction).
- WAIT: `flush` sets `cancel`.
  - On `data_data_ok`: if `cancel`=0, `rdata_stage`←`data_rdata` (writes capture too, harmless) and go to DONE.
  - On `data_data_ok` with `cancel`=1: clear `cancel` and go to IDLE. Discarded data never reaches `rdata_out`.
- DONE: if `~pipe_stall & ~flush`, `rdata_out`←`rdata_stage` and go to IDLE.
  - `flush` in DONE → IDLE without updating `rdata_out`.
  - Otherwise remain in DONE.
- The same EX instruction remains visible with `data_ram_en`=1 during REQ/WAIT/DONE. The bridge ignores inputs outside IDLE, so it never reissues the access.
- `data_data_ok` outside WAIT and `data_addr_ok` outside REQ are ignored.

## Timing
- Reset (`resetn`=0, async): state IDLE, `cancel`=0, `data_req`=0, `data_wr`=0, `data_size`=0, `data_addr`=0, `data_wstrb`=0, `data_wdata`=0, `rdata_stage`=0, `data_ram_rdata`=0, `stall_req`=0.
- Reset mid-transaction aborts immediately. The downstream slave is reset by the same `resetn`.
- `stall_req` (combinational) = (IDLE & `data_ram_en` & ~`flush`) | REQ | WAIT. It is 0 in DONE, so the pipeline advances on DONE's exit edge.
- Best case, with `addr_ok` in the first REQ cycle and `data_ok` one cycle later:
  - cycle 0: IDLE latch, stall.
  - cycle 1: REQ/addr_ok.
  - cycle 2: WAIT/data_ok.
  - cycle 3: DONE, no stall.
  - cycle 4: `data_ram_rdata` valid in MEM.
- Result: 3 stall cycles.
- `data_ram_rdata` changes only on a DONE→IDLE edge, which coincides with pipeline advance. A load stalled in MEM therefore sees stable data even while a younger access is in flight.
- Back-to-back accesses: the bridge enters IDLE after DONE and latches the new EX request in that same IDLE cycle. There is no extra bubble beyond the IDLE cycle.

## Test plan
- Load word at 0x0000_1004, slave `addr_ok` in first REQ cycle, `data_ok` 1 cycle later with 0xDEADBEEF → `data_size`=2, `data_addr`=0x0000_1004, `stall_req` high exactly 3 cycles, `data_ram_rdata`=0xDEADBEEF from cycle 4.
- Stores with wen 0100, 1100, 0111, 1111 at base 0x2000 → (size,addr,wstrb) = (0,0x2002,0100), (1,0x2002,1100), (2,0x2000,0111), (2,0x2000,1111); `data_wr`=1.
- Slave withholds `addr_ok` 5 cycles, then `data_ok` after 3 more → `data_req` and address held constant throughout, `stall_req` high continuously, exactly one transaction issued.
- `flush` in WAIT, then `data_ok` with 0x12345678 → `data_ram_rdata` unchanged (old value), return to IDLE, next load completes normally.
- `pipe_stall`=1 for 4 cycles while in DONE, with prior `rdata_out`=0xAAAA_AAAA and new data 0x5555_5555 → output stays 0xAAAA_AAAA until the first cycle after `pipe_stall` falls.
- `resetn` asserted during REQ → all outputs zero immediately (async), state IDLE after release.
